// File: rtl/magnitude_arbiter_if.sv
// Bus between the magnitude arbiter, its requesters and the shared magnitude engine.
//   req/req_x/req_y : requester levels and 8-bit operands (slice i = requester i)
//   gnt             : one-hot grant pulse back to the requesters
//   eng_*           : start/operands out to the engine, done/result back
//   rsp_*           : tagged response pulse to the requesters
// slave  = arbiter side, master = environment (requesters plus engine).
interface magnitude_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned ID_W = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_x;
  logic [8*NREQ-1:0] req_y;
  logic [NREQ-1:0]   gnt;
  logic              eng_start;
  logic [7:0]        eng_x;
  logic [7:0]        eng_y;
  logic              eng_done;
  logic [7:0]        eng_result;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_err;

  modport slave (
    input  req, req_x, req_y, eng_done, eng_result,
    output gnt, eng_start, eng_x, eng_y, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req, req_x, req_y, eng_done, eng_result,
    input  gnt, eng_start, eng_x, eng_y, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/magnitude_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative magnitude engine among NREQ requesters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : enable, gates new grants only (running operations complete)
//   bus        : requester/engine/response bus (magnitude_arbiter_if.slave)
//   busy       : high whenever the sequencer is not idle
// Sequence: IDLE -(grant)-> ISSUE -> WAIT (until done or watchdog) -> RESPOND -> IDLE.
module magnitude_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  magnitude_arbiter_if.slave    bus,
  output logic                  busy
);

  localparam int unsigned DW    = 8;
  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             eng_start_q, eng_start_d;
  logic [DW-1:0]    eng_x_q, eng_x_d;
  logic [DW-1:0]    eng_y_q, eng_y_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;

  logic [DW-1:0]    opx [NREQ];
  logic [DW-1:0]    opy [NREQ];
  logic             sel_found;
  logic [ID_W-1:0]  sel_k;
  logic [ID_W:0]    sel_sum;
  logic [ID_W-1:0]  sel_idx;

  // Unpack per-requester operand slices.
  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign opx[g] = bus.req_x[g*DW +: DW];
    assign opy[g] = bus.req_y[g*DW +: DW];
  end

  // Round-robin pick: first set req bit from ptr upward, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_k     = '0;
    sel_sum   = '0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      // ptr < NREQ and i < NREQ, so one conditional subtract gives the modulo.
      sel_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (sel_sum >= (ID_W+1)'(NREQ)) begin
        sel_sum = sel_sum - (ID_W+1)'(NREQ);
      end
      sel_idx = sel_sum[ID_W-1:0];
      if (!sel_found && bus.req[sel_idx]) begin
        sel_found = 1'b1;
        sel_k     = sel_idx;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    wait_cnt_d  = wait_cnt_q;
    gnt_d       = '0;
    eng_start_d = 1'b0;
    eng_x_d     = eng_x_q;
    eng_y_d     = eng_y_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ena && sel_found) begin
          state_d     = ST_ISSUE;
          gnt_d       = NREQ'(1) << sel_k;
          eng_start_d = 1'b1;
          eng_x_d     = opx[sel_k];
          eng_y_d     = opy[sel_k];
          id_d        = sel_k;
          ptr_d       = (sel_k == ID_W'(NREQ - 1)) ? '0 : sel_k + ID_W'(1);
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // Done is checked first so it wins a same-cycle collision with the watchdog.
        if (bus.eng_done) begin
          rsp_data_d  = bus.eng_result;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          state_d     = ST_RESPOND;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          state_d     = ST_RESPOND;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      wait_cnt_q  <= '0;
      gnt_q       <= '0;
      eng_start_q <= 1'b0;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      wait_cnt_q  <= wait_cnt_d;
      gnt_q       <= gnt_d;
      eng_start_q <= eng_start_d;
      eng_x_q     <= eng_x_d;
      eng_y_q     <= eng_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_x     = eng_x_q;
  assign bus.eng_y     = eng_y_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_magnitude_arbiter.sv
// Self-checking bench for magnitude_arbiter: behavioural engine, round-robin reference
// model and per-scenario tasks. Inputs driven and outputs sampled on the falling edge.
module tb_magnitude_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 32;
  localparam int unsigned ID_W    = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] tx [NREQ];
  logic [7:0] ty [NREQ];

  // Engine model controls: eng_lat = WAIT cycle on which done pulses, 0 = never.
  int         eng_lat = 9;
  int         eng_cnt = 0;
  logic [7:0] eng_res = '0;
  bit         spur    = 1'b0;

  // Reference round-robin pointer.
  int mptr = 0;

  magnitude_arbiter_if #(.NREQ(NREQ)) bus ();

  magnitude_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign bus.req_x[g*8 +: 8] = tx[g];
    assign bus.req_y[g*8 +: 8] = ty[g];
  end

  function automatic logic [7:0] ref_mag(input int x, input int y);
    int s;
    int r;
    s = x * x + y * y;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return 8'(r);
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    int j;
    for (int i = 0; i < NREQ; i++) begin
      j = (p + i) % NREQ;
      if (m[ID_W'(j)]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int k);
    return (k < 0) ? '0 : NREQ'(1) << k;
  endfunction

  // Behavioural engine: latches on eng_start, pulses done eng_lat WAIT cycles later.
  initial begin
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    forever begin
      @(negedge clk);
      bus.eng_done = 1'b0;
      if (spur) begin
        bus.eng_done   = 1'b1;
        bus.eng_result = 8'hAA;
        spur           = 1'b0;
      end else if (!rst_n) begin
        eng_cnt = 0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          bus.eng_done   = 1'b1;
          bus.eng_result = eng_res;
        end
      end else if (bus.eng_start && eng_lat > 0) begin
        eng_cnt = eng_lat;
        eng_res = ref_mag(int'(bus.eng_x), int'(bus.eng_y));
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
  endtask

  // Advance until a grant is visible; cyc = edges waited (budget if none).
  task automatic wait_gnt(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != '0) break;
    end
  endtask

  // Advance from the ISSUE cycle until rsp_valid; records WAIT cycles and protocol slips.
  task automatic wait_rsp(input int budget, output int waits, output int cyc,
                          output bit unstable, output bit extra);
    logic [7:0] x0, y0;
    x0 = bus.eng_x; y0 = bus.eng_y;
    waits = 0; cyc = 0; unstable = 1'b0; extra = 1'b0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid) break;
      if (bus.gnt != '0 || bus.eng_start) extra = 1'b1;
      if (bus.eng_x !== x0 || bus.eng_y !== y0) unstable = 1'b1;
      if (busy) waits++;
    end
  endtask

  task automatic test_reset();
    logic [33:0] outs;
    rst_n = 1'b1; ena = 1'b0; bus.req = '0;
    for (int i = 0; i < NREQ; i++) begin tx[i] = '0; ty[i] = '0; end
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.gnt, bus.eng_start, bus.eng_x, bus.eng_y, bus.rsp_valid, bus.rsp_id,
            bus.rsp_data, bus.rsp_err, busy};
    n_cmp++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || bus.gnt !== '0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b gnt=%b want 0/0", busy, bus.gnt);
    end
  endtask

  task automatic test_single();
    int cyc, waits; bit unst, extra;
    eng_lat = 9; tx[0] = 8'd3; ty[0] = 8'd4; ena = 1'b1;
    bus.req = 4'b0001;
    wait_gnt(10, cyc);
    n_cmp++;
    if (bus.gnt !== 4'b0001 || cyc != 1) begin
      n_fail++; $display("FAIL single_gnt: gnt=%b after %0d want 0001 after 1", bus.gnt, cyc);
    end
    n_cmp++;
    if (bus.eng_start !== 1'b1 || bus.eng_x !== 8'd3 || bus.eng_y !== 8'd4) begin
      n_fail++; $display("FAIL single_start: start=%b x=%0d y=%0d want 1/3/4",
                         bus.eng_start, bus.eng_x, bus.eng_y);
    end
    mptr = 1;
    bus.req = '0;
    wait_rsp(60, waits, cyc, unst, extra);
    n_cmp++;
    if (waits != 9 || unst || extra) begin
      n_fail++; $display("FAIL single_wait: waits=%0d unstable=%b extra=%b want 9/0/0",
                         waits, unst, extra);
    end
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'd5 || bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp: v=%b id=%0d data=%0d err=%b want 1/0/5/0",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.rsp_data !== 8'd5) begin
      n_fail++; $display("FAIL single_after: v=%b busy=%b data=%0d want 0/0/5",
                         bus.rsp_valid, busy, bus.rsp_data);
    end
  endtask

  task automatic test_fairness();
    int cyc, waits, k; bit unst, extra;
    apply_reset();
    eng_lat = 9; ena = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      tx[i] = 8'($urandom_range(0, 180)); ty[i] = 8'($urandom_range(0, 180));
    end
    tx[2] = 8'd6; ty[2] = 8'd8;
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      k = rr_pick(bus.req, mptr);
      wait_gnt(20, cyc);
      n_cmp++;
      if (bus.gnt !== onehot(k)) begin
        n_fail++; $display("FAIL fair_gnt%0d: gnt=%b want %b", n, bus.gnt, onehot(k));
      end
      mptr = (k + 1) % NREQ;
      wait_rsp(60, waits, cyc, unst, extra);
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(k) || bus.rsp_err !== 1'b0 ||
          bus.rsp_data !== ref_mag(int'(tx[k]), int'(ty[k]))) begin
        n_fail++; $display("FAIL fair_rsp%0d: v=%b id=%0d data=%0d err=%b want 1/%0d/%0d/0", n,
                           bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, k,
                           ref_mag(int'(tx[k]), int'(ty[k])));
      end
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc, c2, waits, k; bit unst, extra;
    eng_lat = 1; ena = 1'b1;
    bus.req = 4'b0011;
    k = rr_pick(bus.req, mptr);
    wait_gnt(10, cyc);
    mptr = (k + 1) % NREQ;
    for (int n = 0; n < 3; n++) begin
      wait_rsp(20, waits, cyc, unst, extra);
      k = rr_pick(bus.req, mptr);
      wait_gnt(10, c2);
      n_cmp++;
      if (cyc + c2 != 4 || bus.gnt !== onehot(k)) begin
        n_fail++; $display("FAIL b2b_gap%0d: gap=%0d gnt=%b want 4/%b", n, cyc + c2, bus.gnt, onehot(k));
      end
      mptr = (k + 1) % NREQ;
    end
    bus.req = '0;
    wait_rsp(20, waits, cyc, unst, extra);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int cyc, waits, k, lat; bit unst, extra;
    logic [NREQ-1:0] m;
    ena = 1'b1;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        tx[i] = 8'($urandom_range(0, 180)); ty[i] = 8'($urandom_range(0, 180));
      end
      lat = int'($urandom_range(1, 12));
      eng_lat = lat;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      bus.req = m;
      k = rr_pick(m, mptr);
      wait_gnt(8, cyc);
      n_cmp++;
      if (bus.gnt !== onehot(k) || bus.eng_x !== tx[k] || bus.eng_y !== ty[k]) begin
        n_fail++; $display("FAIL rand_gnt%0d: gnt=%b x=%0d y=%0d want %b/%0d/%0d", n,
                           bus.gnt, bus.eng_x, bus.eng_y, onehot(k), tx[k], ty[k]);
      end
      mptr = (k + 1) % NREQ;
      bus.req = '0;
      wait_rsp(60, waits, cyc, unst, extra);
      n_cmp++;
      if (waits != lat || unst || extra || bus.rsp_id !== ID_W'(k) || bus.rsp_err !== 1'b0 ||
          bus.rsp_data !== ref_mag(int'(tx[k]), int'(ty[k]))) begin
        n_fail++; $display("FAIL rand_rsp%0d: waits=%0d id=%0d data=%0d err=%b want %0d/%0d/%0d/0", n,
                           waits, bus.rsp_id, bus.rsp_data, bus.rsp_err, lat, k,
                           ref_mag(int'(tx[k]), int'(ty[k])));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int cyc, waits, k; bit unst, extra;
    ena = 1'b1; eng_lat = 0;
    tx[2] = 8'd10; ty[2] = 8'd20;
    bus.req = 4'b0100;
    k = rr_pick(bus.req, mptr);
    wait_gnt(10, cyc);
    mptr = (k + 1) % NREQ;
    bus.req = '0;
    wait_rsp(80, waits, cyc, unst, extra);
    n_cmp++;
    if (waits != TIMEOUT || cyc != TIMEOUT + 1) begin
      n_fail++; $display("FAIL timeout_len: waits=%0d cyc=%0d want %0d/%0d", waits, cyc, TIMEOUT, TIMEOUT + 1);
    end
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 8'd0 || bus.rsp_id !== ID_W'(k)) begin
      n_fail++; $display("FAIL timeout_rsp: v=%b err=%b data=%0d id=%0d want 1/1/0/%0d",
                         bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_id, k);
    end
    eng_lat = 5; tx[3] = 8'd12; ty[3] = 8'd5;
    bus.req = 4'b1000;
    k = rr_pick(bus.req, mptr);
    wait_gnt(10, cyc);
    mptr = (k + 1) % NREQ;
    bus.req = '0;
    wait_rsp(60, waits, cyc, unst, extra);
    n_cmp++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_data !== 8'd13 || bus.rsp_id !== ID_W'(k)) begin
      n_fail++; $display("FAIL timeout_next: err=%b data=%0d id=%0d want 0/13/%0d",
                         bus.rsp_err, bus.rsp_data, bus.rsp_id, k);
    end
  endtask

  task automatic test_collision();
    int cyc, waits, k; bit unst, extra;
    ena = 1'b1; eng_lat = TIMEOUT;
    tx[1] = 8'd7; ty[1] = 8'd0;
    bus.req = 4'b0010;
    k = rr_pick(bus.req, mptr);
    wait_gnt(10, cyc);
    mptr = (k + 1) % NREQ;
    bus.req = '0;
    wait_rsp(80, waits, cyc, unst, extra);
    n_cmp++;
    if (waits != TIMEOUT || bus.rsp_err !== 1'b0 || bus.rsp_data !== 8'd7) begin
      n_fail++; $display("FAIL collision: waits=%0d err=%b data=%0d want %0d/0/7",
                         waits, bus.rsp_err, bus.rsp_data, TIMEOUT);
    end
  endtask

  task automatic test_ena();
    int cyc, waits, k, seen; bit unst, extra;
    ena = 1'b0; eng_lat = 6;
    tx[1] = 8'd9; ty[1] = 8'd12;
    bus.req = 4'b0010;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) spur = 1'b1;
      @(negedge clk);
      if (bus.gnt != '0 || bus.rsp_valid || busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL ena_block: activity cycles=%0d want 0", seen); end
    ena = 1'b1;
    k = rr_pick(bus.req, mptr);
    wait_gnt(10, cyc);
    n_cmp++;
    if (bus.gnt !== onehot(k)) begin
      n_fail++; $display("FAIL ena_gnt: gnt=%b want %b", bus.gnt, onehot(k));
    end
    mptr = (k + 1) % NREQ;
    bus.req = 4'b1111;
    ena = 1'b0;
    wait_rsp(60, waits, cyc, unst, extra);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(k) || bus.rsp_data !== 8'd15 || bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL ena_drop_rsp: v=%b id=%0d data=%0d err=%b want 1/%0d/15/0",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, k);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.gnt != '0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL ena_nogrant: grants=%0d want 0", seen); end
    ena = 1'b1;
    k = rr_pick(bus.req, mptr);
    wait_gnt(10, cyc);
    n_cmp++;
    if (bus.gnt !== onehot(k)) begin
      n_fail++; $display("FAIL ena_resume: gnt=%b want %b", bus.gnt, onehot(k));
    end
    mptr = (k + 1) % NREQ;
    bus.req = '0;
    wait_rsp(60, waits, cyc, unst, extra);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, waits, seen; bit unst, extra;
    logic [33:0] outs;
    ena = 1'b1; eng_lat = 20;
    bus.req = 4'b0100;
    wait_gnt(10, cyc);
    bus.req = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs = {bus.gnt, bus.eng_start, bus.eng_x, bus.eng_y, bus.rsp_valid, bus.rsp_id,
            bus.rsp_data, bus.rsp_err, busy};
    n_cmp++;
    if (outs !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h want 0", outs); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL midreset_silent: activity cycles=%0d want 0", seen); end
    eng_lat = 3;
    tx[0] = 8'd8; ty[0] = 8'd15;
    bus.req = 4'b1111;
    wait_gnt(10, cyc);
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin
      n_fail++; $display("FAIL midreset_ptr: gnt=%b want 0001", bus.gnt);
    end
    mptr = 1;
    bus.req = '0;
    wait_rsp(60, waits, cyc, unst, extra);
    n_cmp++;
    if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'd17 || waits != 3) begin
      n_fail++; $display("FAIL midreset_op: id=%0d data=%0d waits=%0d want 0/17/3",
                         bus.rsp_id, bus.rsp_data, waits);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_random();
    test_timeout();
    test_collision();
    test_ena();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
